// File: rtl/tic_tac_toe_nxn.sv
// N x N tic-tac-toe referee: accepts moves, flags illegal ones, scans four directions after each move.
// Optional move timer compiled in with `define MOVE_TIMER_EN.
module tic_tac_toe_nxn #(
  parameter int BOARD_N        = 3,
  parameter int WIN_K          = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int unsigned CW   = ($clog2(BOARD_N) > 1) ? $clog2(BOARD_N) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           new_game,
  input  logic                           first_player,
  input  logic                           move_valid,
  input  logic [CW-1:0]                  move_row,
  input  logic [CW-1:0]                  move_col,
  output logic                           move_ready,
  output logic                           move_reject,
  output logic [2*BOARD_N*BOARD_N-1:0]   board,
  output logic                           x_or_o,
  output logic [1:0]                     result,
  output logic                           timeout
);

  localparam int unsigned CELLS = BOARD_N * BOARD_N;
  localparam int unsigned BW    = 2 * CELLS;
  localparam int unsigned MCW   = $clog2(CELLS + 1);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t           state_q;
  logic [MCW-1:0]   move_cnt_q;
  logic [CW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic [1:0]       dir_q;
  logic             win_q;

  logic [1:0]       mark_c;
  logic             req_bad_c;
  logic             line_hit_c;
  int               req_row_c, req_col_c;
  int               dr_c, dc_c, r0_c, c0_c, len_c;

  if (BOARD_N < 3 || BOARD_N > 8) begin : g_bad_board
    $error("BOARD_N must be in 3..8");
  end
  if (WIN_K < 3 || WIN_K > BOARD_N) begin : g_bad_win
    $error("WIN_K must be in 3..BOARD_N");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // Off-board coordinates read as empty so line scans stop at the edge.
  function automatic logic [1:0] cell_at(input logic [BW-1:0] b, input int r, input int c);
    if (r < 0 || c < 0 || r >= BOARD_N || c >= BOARD_N) return 2'b00;
    return b[2*(r*BOARD_N+c) +: 2];
  endfunction

  function automatic int run_len(input logic [BW-1:0] b, input int r0, input int c0,
                                 input int dr, input int dc, input logic [1:0] mark);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int k = 1; k < WIN_K; k++) begin
      if (run && cell_at(b, r0 + k*dr, c0 + k*dc) == mark) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

  assign mark_c = x_or_o ? 2'b10 : 2'b01;

  always_comb begin
    req_row_c = 32'(move_row);
    req_col_c = 32'(move_col);
    req_bad_c = (req_row_c >= BOARD_N) || (req_col_c >= BOARD_N) ||
                (cell_at(board, req_row_c, req_col_c) != 2'b00);
  end

  // One direction per CHECK cycle: 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
  always_comb begin
    dr_c = 0;
    dc_c = 1;
    case (dir_q)
      2'd0:    begin dr_c = 0; dc_c = 1;  end
      2'd1:    begin dr_c = 1; dc_c = 0;  end
      2'd2:    begin dr_c = 1; dc_c = 1;  end
      default: begin dr_c = 1; dc_c = -1; end
    endcase
    r0_c       = 32'(row_q);
    c0_c       = 32'(col_q);
    len_c      = 1 + run_len(board, r0_c, c0_c, dr_c, dc_c, mark_c)
                   + run_len(board, r0_c, c0_c, -dr_c, -dc_c, mark_c);
    line_hit_c = (len_c >= WIN_K);
  end

`ifdef MOVE_TIMER_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      move_ready  <= 1'b1;
      move_reject <= 1'b0;
      board       <= '0;
      x_or_o      <= 1'b0;
      result      <= 2'b00;
      move_cnt_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      dir_q       <= 2'd0;
      win_q       <= 1'b0;
`ifdef MOVE_TIMER_EN
      timeout     <= 1'b0;
      timer_q     <= '0;
`endif
    end else begin
      move_reject <= 1'b0;
      if (new_game) begin
        state_q    <= IDLE;
        move_ready <= 1'b1;
        board      <= '0;
        x_or_o     <= first_player;
        result     <= 2'b00;
        move_cnt_q <= '0;
        dir_q      <= 2'd0;
        win_q      <= 1'b0;
`ifdef MOVE_TIMER_EN
        timeout    <= 1'b0;
        timer_q    <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            if (move_valid) begin
`ifdef MOVE_TIMER_EN
              timer_q <= '0;
`endif
              if (req_bad_c) begin
                move_reject <= 1'b1;
              end else begin
                board[2*(req_row_c*BOARD_N+req_col_c) +: 2] <= mark_c;
                move_cnt_q <= move_cnt_q + MCW'(1);
                row_q      <= move_row;
                col_q      <= move_col;
                dir_q      <= 2'd0;
                win_q      <= 1'b0;
                state_q    <= CHECK;
                move_ready <= 1'b0;
              end
            end
`ifdef MOVE_TIMER_EN
            else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
              result     <= x_or_o ? 2'b01 : 2'b10;
              timeout    <= 1'b1;
              state_q    <= DONE;
              move_ready <= 1'b0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
`endif
          end
          CHECK: begin
            dir_q <= dir_q + 2'd1;
            win_q <= win_q | line_hit_c;
            if (dir_q == 2'd3) begin
              // Win is tested before draw so a line on the last cell counts as a win.
              if (win_q || line_hit_c) begin
                result     <= x_or_o ? 2'b10 : 2'b01;
                state_q    <= DONE;
                move_ready <= 1'b0;
              end else if (move_cnt_q == MCW'(CELLS)) begin
                result     <= 2'b11;
                state_q    <= DONE;
                move_ready <= 1'b0;
              end else begin
                x_or_o     <= ~x_or_o;
                state_q    <= IDLE;
                move_ready <= 1'b1;
              end
            end
          end
          DONE: begin
          end
          default: begin
            state_q    <= IDLE;
            move_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tic_tac_toe_nxn.sv
// Directed bench for tic_tac_toe_nxn: 3x3 default board, 5x5/K=4 board and a 16-cycle timer instance.
module tb_tic_tac_toe_nxn;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  // 3x3 default instance
  logic        a_ng, a_fp, a_mv, a_ready, a_rej, a_xo, a_to;
  logic [1:0]  a_row, a_col, a_res;
  logic [17:0] a_board;

  // 5x5, WIN_K=4 instance
  logic        b_ng, b_fp, b_mv, b_ready, b_rej, b_xo, b_to;
  logic [2:0]  b_row, b_col;
  logic [1:0]  b_res;
  logic [49:0] b_board;

  // 3x3 instance with a short move timer
  logic        t_ng, t_fp, t_mv, t_ready, t_rej, t_xo, t_to;
  logic [1:0]  t_row, t_col, t_res;
  logic [17:0] t_board;

  tic_tac_toe_nxn dut_a (
    .clock(clk), .reset(rst_n), .new_game(a_ng), .first_player(a_fp), .move_valid(a_mv),
    .move_row(a_row), .move_col(a_col), .move_ready(a_ready), .move_reject(a_rej),
    .board(a_board), .x_or_o(a_xo), .result(a_res), .timeout(a_to));

  tic_tac_toe_nxn #(.BOARD_N(5), .WIN_K(4)) dut_b (
    .clock(clk), .reset(rst_n), .new_game(b_ng), .first_player(b_fp), .move_valid(b_mv),
    .move_row(b_row), .move_col(b_col), .move_ready(b_ready), .move_reject(b_rej),
    .board(b_board), .x_or_o(b_xo), .result(b_res), .timeout(b_to));

  tic_tac_toe_nxn #(.TIMEOUT_CYCLES(16)) dut_t (
    .clock(clk), .reset(rst_n), .new_game(t_ng), .first_player(t_fp), .move_valid(t_mv),
    .move_row(t_row), .move_col(t_col), .move_ready(t_ready), .move_reject(t_rej),
    .board(t_board), .x_or_o(t_xo), .result(t_res), .timeout(t_to));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_new_game(input logic fp);
    a_ng = 1'b1; a_fp = fp;
    tick();
    a_ng = 1'b0;
  endtask

  task automatic a_move(input int r, input int c);
    int n = 0;
    while (!a_ready && n < 20) begin tick(); n++; end
    if (!a_ready) check("a_ready_wait", 64'(a_ready), 64'd1);
    a_mv = 1'b1; a_row = 2'(r); a_col = 2'(c);
    tick();
    a_mv = 1'b0;
  endtask

  task automatic b_move(input int r, input int c);
    int n = 0;
    while (!b_ready && n < 20) begin tick(); n++; end
    if (!b_ready) check("b_ready_wait", 64'(b_ready), 64'd1);
    b_mv = 1'b1; b_row = 3'(r); b_col = 3'(c);
    tick();
    b_mv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_ng = 0; a_fp = 0; a_mv = 0; a_row = 0; a_col = 0;
    b_ng = 0; b_fp = 0; b_mv = 0; b_row = 0; b_col = 0;
    t_ng = 0; t_fp = 0; t_mv = 0; t_row = 0; t_col = 0;
    #22;
    check("rst_board", 64'(a_board), 64'd0);
    check("rst_result", 64'(a_res), 64'd0);
    check("rst_xo", 64'(a_xo), 64'd0);
    check("rst_ready", 64'(a_ready), 64'd1);
    check("rst_reject", 64'(a_rej), 64'd0);
    check("rst_timeout", 64'(a_to), 64'd0);
    rst_n = 1'b1;
    tick();

    // X wins on the top row
    a_new_game(1'b0);
    a_move(0, 0);
    repeat (3) tick();
    check("lat_not_ready", 64'(a_ready), 64'd0);
    tick();
    check("lat_ready", 64'(a_ready), 64'd1);
    check("xo_after_x", 64'(a_xo), 64'd1);
    a_move(1, 0);
    a_move(0, 1);
    a_move(1, 1);
    a_move(0, 2);
    repeat (3) tick();
    check("win_pre", 64'(a_res), 64'd0);
    tick();
    check("win_x", 64'(a_res), 64'd1);
    check("win_xo", 64'(a_xo), 64'd0);
    check("win_ready", 64'(a_ready), 64'd0);
    check("win_board", 64'(a_board), 64'h295);
    a_mv = 1'b1; a_row = 2'd2; a_col = 2'd2;
    tick();
    a_mv = 1'b0;
    repeat (4) tick();
    check("done_hold_res", 64'(a_res), 64'd1);
    check("done_hold_board", 64'(a_board), 64'h295);
    check("done_no_reject", 64'(a_rej), 64'd0);

    // Illegal moves: occupied cell and row out of range
    a_new_game(1'b0);
    a_move(1, 1);
    repeat (4) tick();
    check("ill_xo_o", 64'(a_xo), 64'd1);
    a_move(1, 1);
    check("occ_reject", 64'(a_rej), 64'd1);
    tick();
    check("occ_reject_end", 64'(a_rej), 64'd0);
    check("occ_board", 64'(a_board), 64'h100);
    check("occ_xo", 64'(a_xo), 64'd1);
    check("occ_ready", 64'(a_ready), 64'd1);
    a_move(3, 0);
    check("row3_reject", 64'(a_rej), 64'd1);
    tick();
    check("row3_reject_end", 64'(a_rej), 64'd0);
    check("row3_board", 64'(a_board), 64'h100);
    check("row3_xo", 64'(a_xo), 64'd1);

    // Draw: X O X / X O O / O X X
    a_new_game(1'b0);
    a_move(0, 0); a_move(0, 1); a_move(0, 2);
    a_move(1, 1); a_move(1, 0); a_move(1, 2);
    a_move(2, 1); a_move(2, 0);
    repeat (4) tick();
    check("draw_pre", 64'(a_res), 64'd0);
    a_move(2, 2);
    repeat (4) tick();
    check("draw_res", 64'(a_res), 64'd3);
    check("draw_board", 64'(a_board), 64'h16A59);
    check("draw_ready", 64'(a_ready), 64'd0);
    check("draw_xo", 64'(a_xo), 64'd0);
    a_mv = 1'b1; a_row = 2'd0; a_col = 2'd0;
    tick();
    a_mv = 1'b0;
    check("draw_ign_rej", 64'(a_rej), 64'd0);
    check("draw_ign_board", 64'(a_board), 64'h16A59);
    check("draw_ign_res", 64'(a_res), 64'd3);

    // 5x5, K=4: O on the anti-diagonal
    b_ng = 1'b1; b_fp = 1'b1;
    tick();
    b_ng = 1'b0;
    check("b_ng_xo", 64'(b_xo), 64'd1);
    b_move(0, 4); b_move(0, 0); b_move(1, 3); b_move(0, 1); b_move(2, 2);
    repeat (4) tick();
    check("b_three_res", 64'(b_res), 64'd0);
    check("b_three_ready", 64'(b_ready), 64'd1);
    b_move(4, 4); b_move(3, 1);
    repeat (4) tick();
    check("b_win_res", 64'(b_res), 64'd2);
    check("b_win_xo", 64'(b_xo), 64'd1);
    check("b_cell16", 64'(b_board[32 +: 2]), 64'd2);
    check("b_cell4", 64'(b_board[8 +: 2]), 64'd2);
    check("b_cell24", 64'(b_board[48 +: 2]), 64'd1);

    // Reset in the middle of CHECK
    a_new_game(1'b0);
    a_move(1, 2);
    tick();
    rst_n = 1'b0;
    #2;
    check("rst_mid_board", 64'(a_board), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_ready", 64'(a_ready), 64'd1);
    check("rel_board", 64'(a_board), 64'd0);
    check("rel_res", 64'(a_res), 64'd0);
    a_ng = 1'b1; a_fp = 1'b0; a_mv = 1'b1; a_row = 2'd2; a_col = 2'd2;
    tick();
    a_ng = 1'b0; a_mv = 1'b0;
    check("ng_drop_board", 64'(a_board), 64'd0);
    check("ng_drop_rej", 64'(a_rej), 64'd0);
    check("ng_drop_ready", 64'(a_ready), 64'd1);
    tick();
    check("ng_drop_board2", 64'(a_board), 64'd0);
    a_new_game(1'b1);
    check("ng_fp1_xo", 64'(a_xo), 64'd1);

    // Move timer: 16 idle cycles with X to move
    t_ng = 1'b1; t_fp = 1'b0;
    tick();
    t_ng = 1'b0;
    repeat (15) tick();
    check("tmr_pre_res", 64'(t_res), 64'd0);
    check("tmr_pre_ready", 64'(t_ready), 64'd1);
    tick();
`ifdef MOVE_TIMER_EN
    check("tmr_res", 64'(t_res), 64'd2);
    check("tmr_flag", 64'(t_to), 64'd1);
    check("tmr_ready", 64'(t_ready), 64'd0);
`else
    check("tmr_res", 64'(t_res), 64'd0);
    check("tmr_flag", 64'(t_to), 64'd0);
    check("tmr_ready", 64'(t_ready), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tic_tac_toe_nxn.md
TIC_TAC_TOE_NXN -- requirements
Module: tic_tac_toe_nxn

Interface
REQ-001 SHALL have parameter BOARD_N, default 3: board is BOARD_N x BOARD_N; legal range 3..8.
REQ-002 SHALL have parameter WIN_K, default 3: marks in a row needed to win; legal range 3..BOARD_N.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: move time limit in cycles; used only under MOVE_TIMER_EN.
REQ-004 SHALL define CW = max(1, $clog2(BOARD_N)) as the coordinate width.
REQ-005 clock  input  1  single clock; all logic rising-edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 new_game  input  1  synchronous clear of the current game.
REQ-008 first_player  input  1  side to move first, sampled on new_game; 0=X, 1=O.
REQ-009 move_valid  input  1  move request.
REQ-010 move_row, move_col  input  CW each  target cell coordinates.
REQ-011 move_ready  output  1  block can accept a move.
REQ-012 move_reject  output  1  one-cycle pulse: accepted move was illegal.
REQ-013 board  output  2*BOARD_N*BOARD_N  cell (r,c) at bits [2*(r*BOARD_N+c)+:2]; 00 empty, 01 X, 10 O.
REQ-014 x_or_o  output  1  side to move; 0=X, 1=O.
REQ-015 result  output  2  00 in progress, 01 X won, 10 O won, 11 draw.
REQ-016 timeout  output  1  game ended on move timeout.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 States SHALL be IDLE, CHECK, DONE; move_ready SHALL equal (state==IDLE).
REQ-019 A move SHALL be accepted on an edge where move_valid && move_ready.
- Illegal move: row or col >= BOARD_N, or target cell not 00.
- On an illegal move, move_reject SHALL be 1 for the next cycle only; board, x_or_o and state stay unchanged.
REQ-020 On a legal move, the cell SHALL be written with x_or_o's mark at the accept edge.
- The move count SHALL increment and state SHALL go to CHECK.
REQ-021 CHECK SHALL last exactly 4 cycles, one per direction: horizontal, vertical, diagonal, anti-diagonal.
- Each cycle counts same-mark cells contiguous with the placed cell, up to WIN_K-1 each side.
- A count of WIN_K or more sets an internal win flag.
REQ-022 On the 4th CHECK cycle:
- win: result = 01 or 10 per mover, go to DONE, x_or_o unchanged;
- else if move count == BOARD_N*BOARD_N: result = 11, go to DONE;
- else: toggle x_or_o, go to IDLE.
REQ-023 Accept-to-next-move_ready latency SHALL be 5 edges (accept + 4 CHECK).
REQ-024 DONE SHALL hold board and result indefinitely; move_valid is ignored.
REQ-025 new_game SHALL act in any state with priority over a concurrent move.
- Clears board, move count, result, timeout and move_reject.
- Sets x_or_o = first_player and state = IDLE.
- A concurrent move is dropped and not rejected.
REQ-026 A win takes precedence over a draw when the final cell completes a line.

Reset
REQ-027 reset low SHALL asynchronously force state = IDLE, board = 0, move count = 0, result = 00, x_or_o = 0, move_reject = 0, timeout = 0, timer = 0.
REQ-028 Reset mid-CHECK SHALL abandon the pending move evaluation; the first cycle after release is IDLE with an empty board.

Configuration
REQ-029 Macro MOVE_TIMER_EN SHALL compile in a move timer.
- Counts cycles while in IDLE; cleared on any accepted move (legal or illegal) and on new_game.
- On reaching TIMEOUT_CYCLES-1 in IDLE: result = opponent wins, timeout = 1, go to DONE.
- A move accepted on that same edge takes precedence over the timeout.
REQ-030 Without MOVE_TIMER_EN, no timer logic SHALL exist and timeout SHALL be constant 0.

Verification
REQ-031 Defaults, new_game with first_player=0; X (0,0),(0,1),(0,2) and O (1,0),(1,1), each accepted after move_ready returns.
- Required: result=01 exactly 4 cycles after the 5th accept, then held in DONE.
REQ-032 Legal move followed by a move to an occupied cell, then a move with row=3.
- Required: move_reject pulses once for each bad move; x_or_o and board unchanged.
REQ-033 Fill the 3x3 board with no line (X,O,X / X,O,O / O,X,X order).
- Required: result=11 after the 9th move's CHECK; move_valid in DONE ignored.
REQ-034 BOARD_N=5, WIN_K=4: O plays anti-diagonal (0,4),(1,3),(2,2),(3,1); X plays non-line cells.
- Required: result=10; three in a row alone yields 00.
REQ-035 Assert reset during CHECK, then new_game with move_valid high; separately, new_game with first_player=1.
- Required: empty board, IDLE, move dropped; x_or_o=1 after the new_game.
REQ-036 MOVE_TIMER_EN, TIMEOUT_CYCLES=16: no move for 16 IDLE cycles with X to move.
- Required: result=10, timeout=1; without the macro, result stays 00.
